// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared state encoding, default sizes and index wrap helper for the bus arbiter.
package bus_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_OWNED = 1'b1} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_SRC = 8;
  function automatic int wrap_idx(input int v, input int n);
    return v >= n ? v - n : v;
  endfunction
endpackage

// File: rtl/bus_arbiter_pick.sv
// arb_pick: combinational winner search, fixed priority or round-robin from ptr.
module arb_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [SEL_W-1:0] winner,
  output logic             any_req
);
  logic [2*N_SRC-1:0] dbl;
  logic [SEL_W-1:0] start;
  // Doubling the vector turns the wrap-around search into a straight upward scan.
  always_comb begin
    dbl = {req, req};
    start = mode ? ptr : '0;
    winner = '0;
    for (int k = N_SRC - 1; k >= 0; k--)
      if (dbl[int'(start) + k]) winner = SEL_W'(wrap_idx(int'(start) + k, N_SRC));
    any_req = |req;
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: N-source arbiter with one-hot grant, lock and a registered shared bus output.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_SRC = DEF_N_SRC,
  parameter int RR = 1,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       req,
  input  logic [N_SRC*WIDTH-1:0] in_flat,
  input  logic                   lock,
  output logic [N_SRC-1:0]       gnt,
  output logic [SEL_W-1:0]       gnt_idx,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid
);
  state_t state, state_n;
  logic [N_SRC-1:0] gnt_n;
  logic [SEL_W-1:0] idx_n, ptr_n, rr_ptr, win;
  logic any_req, hold, take;
  arb_pick #(.N_SRC(N_SRC)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .mode(RR != 0),
    .winner(win),
    .any_req(any_req)
  );
  // Lock dominates the owner's own request; a released grant re-arbitrates in the same cycle.
  always_comb begin
    hold = state == ST_OWNED && (req[gnt_idx] || lock);
    take = !hold && any_req;
    state_n = (hold || take) ? ST_OWNED : ST_IDLE;
    gnt_n = hold ? gnt : take ? N_SRC'(1) << win : '0;
    idx_n = take ? win : gnt_idx;
    ptr_n = take ? SEL_W'(wrap_idx(int'(win) + 1, N_SRC)) : rr_ptr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt <= '0;
      gnt_idx <= '0;
      rr_ptr <= '0;
      out <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      gnt_idx <= idx_n;
      rr_ptr <= ptr_n;
      if (state == ST_OWNED) begin
        out <= in_flat[gnt_idx*WIDTH +: WIDTH];
        out_valid <= req[gnt_idx];
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized checks of fixed-priority and round-robin arbiters.
module tb_bus_arbiter;
  logic clk = 0, rst = 1, lock = 0;
  logic [7:0] req = 0;
  logic [63:0] in_flat = 0;
  logic [7:0] g_fp, g_rr, o_fp, o_rr;
  logic [2:0] i_fp, i_rr;
  logic v_fp, v_rr;
  int tests = 0, fails = 0;
  int m_own[2] = '{-1, -1};
  int m_idx[2] = '{0, 0};
  int m_ptr[2] = '{0, 0};
  logic [7:0] m_out[2] = '{8'h00, 8'h00};
  logic m_ov[2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  bus_arbiter #(.WIDTH(8), .N_SRC(8), .RR(0)) dut_fp (
    .clk(clk), .rst(rst), .req(req), .in_flat(in_flat), .lock(lock),
    .gnt(g_fp), .gnt_idx(i_fp), .out(o_fp), .out_valid(v_fp)
  );
  bus_arbiter #(.WIDTH(8), .N_SRC(8), .RR(1)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .in_flat(in_flat), .lock(lock),
    .gnt(g_rr), .gnt_idx(i_rr), .out(o_rr), .out_valid(v_rr)
  );

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) if (r[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  // Reference model: owner as an integer (-1 = none), updated from the arbitration rules.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_own[k] = -1; m_idx[k] = 0; m_ptr[k] = 0; m_out[k] = 0; m_ov[k] = 0;
      end else begin
        int o, w;
        o = m_own[k];
        if (o >= 0) begin
          m_out[k] = in_flat[o*8 +: 8];
          m_ov[k] = req[o];
        end else m_ov[k] = 0;
        if (!(o >= 0 && (req[o] || lock))) begin
          w = pick(req, k == 1 ? m_ptr[k] : 0);
          m_own[k] = w;
          if (w >= 0) begin
            m_idx[k] = w;
            m_ptr[k] = (w + 1) % 8;
          end
        end
      end
    end
  end

  function automatic logic [19:0] ev(input int k);
    return {m_own[k] < 0 ? 8'h00 : 8'(1 << m_own[k]), 3'(m_idx[k]), m_out[k], m_ov[k]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1; req = 8'hFF; lock = 1;
    tick(2);
    tests++;
    if ({g_fp, i_fp, o_fp, v_fp} !== 20'h0) begin
      fails++; $display("FAIL reset_fp: got %h expected %h", {g_fp, i_fp, o_fp, v_fp}, 20'h0);
    end
    tests++;
    if ({g_rr, i_rr, o_rr, v_rr} !== 20'h0) begin
      fails++; $display("FAIL reset_rr: got %h expected %h", {g_rr, i_rr, o_rr, v_rr}, 20'h0);
    end
    rst = 0; lock = 0;
    tick(1);
    tests++;
    if (g_fp !== 8'h01 || g_rr !== 8'h01) begin
      fails++; $display("FAIL first_grant: got %h/%h expected 01/01", g_fp, g_rr);
    end
    req = 0;
    tick(2);
  endtask

  task automatic test_single;
    in_flat[16 +: 8] = 8'hA5; req = 8'h04;
    tick(1);
    tests++;
    if (g_rr !== 8'h04 || i_rr !== 3'd2) begin
      fails++; $display("FAIL single_gnt: got %h/%0d expected 04/2", g_rr, i_rr);
    end
    tick(1);
    tests++;
    if (o_rr !== 8'hA5 || v_rr !== 1'b1) begin
      fails++; $display("FAIL single_out: got %h/%b expected a5/1", o_rr, v_rr);
    end
    tick(2);
    tests++;
    if (g_rr !== 8'h04 || o_rr !== 8'hA5 || v_rr !== 1'b1) begin
      fails++; $display("FAIL single_hold: got %h/%h/%b expected 04/a5/1", g_rr, o_rr, v_rr);
    end
    req = 0;
    tick(2);
    tests++;
    if (g_rr !== 8'h00 || v_rr !== 1'b0) begin
      fails++; $display("FAIL single_release: got %h/%b expected 00/0", g_rr, v_rr);
    end
  endtask

  task automatic test_fixed;
    req = 8'h90;
    tick(1);
    tests++;
    if (i_fp !== 3'd4 || g_fp !== 8'h10) begin
      fails++; $display("FAIL fixed_low: got %0d/%h expected 4/10", i_fp, g_fp);
    end
    req = 8'h80;
    tick(1);
    tests++;
    if (i_fp !== 3'd7 || g_fp !== 8'h80) begin
      fails++; $display("FAIL fixed_handoff: got %0d/%h expected 7/80", i_fp, g_fp);
    end
    req = 0;
    tick(2);
  endtask

  task automatic test_round_robin;
    rst = 1; tick(1); rst = 0;
    req = 8'hFF;
    tick(1);
    tests++;
    if (i_rr !== 3'd0) begin
      fails++; $display("FAIL rr_first: got %0d expected 0", i_rr);
    end
    for (int i = 1; i <= 8; i++) begin
      req = 8'hFF & ~(8'h01 << ((i - 1) % 8));
      tick(1);
      req = 8'hFF;
      tests++;
      if (i_rr !== 3'(i % 8) || g_rr !== 8'(1 << (i % 8))) begin
        fails++; $display("FAIL rr_order_%0d: got %0d/%h expected %0d", i, i_rr, g_rr, i % 8);
      end
    end
    req = 0;
    tick(2);
  endtask

  task automatic test_lock;
    rst = 1; tick(1); rst = 0;
    req = 8'h08;
    tick(1);
    lock = 1; req = 8'h20;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      tests++;
      if (g_rr !== 8'h08 || v_rr !== 1'b0) begin
        fails++; $display("FAIL lock_hold_%0d: got %h/%b expected 08/0", i, g_rr, v_rr);
      end
    end
    lock = 0;
    tick(1);
    tests++;
    if (g_rr !== 8'h20 || i_rr !== 3'd5) begin
      fails++; $display("FAIL lock_release: got %h/%0d expected 20/5", g_rr, i_rr);
    end
  endtask

  task automatic test_reset_mid;
    in_flat[48 +: 8] = 8'h6C; req = 8'h40;
    tick(3);
    tests++;
    if (g_rr !== 8'h40 || o_rr !== 8'h6C || v_rr !== 1'b1) begin
      fails++; $display("FAIL mid_stream: got %h/%h/%b expected 40/6c/1", g_rr, o_rr, v_rr);
    end
    rst = 1;
    tick(1);
    rst = 0;
    tests++;
    if ({g_rr, i_rr, o_rr, v_rr} !== 20'h0) begin
      fails++; $display("FAIL mid_reset: got %h expected %h", {g_rr, i_rr, o_rr, v_rr}, 20'h0);
    end
    tick(1);
    tests++;
    if (g_rr !== 8'h40 || v_rr !== 1'b0) begin
      fails++; $display("FAIL mid_regrant: got %h/%b expected 40/0", g_rr, v_rr);
    end
    tick(1);
    tests++;
    if (o_rr !== 8'h6C || v_rr !== 1'b1) begin
      fails++; $display("FAIL mid_reout: got %h/%b expected 6c/1", o_rr, v_rr);
    end
    req = 0;
    tick(2);
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      req = 8'($urandom) & 8'($urandom);
      lock = $urandom_range(0, 7) == 0;
      rst = $urandom_range(0, 99) == 0;
      in_flat = {$urandom, $urandom};
      tick(1);
      tests++;
      if ({g_fp, i_fp, o_fp, v_fp} !== ev(0)) begin
        fails++; $display("FAIL rand_fp_%0d: got %h expected %h", i, {g_fp, i_fp, o_fp, v_fp}, ev(0));
      end
      tests++;
      if ({g_rr, i_rr, o_rr, v_rr} !== ev(1)) begin
        fails++; $display("FAIL rand_rr_%0d: got %h expected %h", i, {g_rr, i_rr, o_rr, v_rr}, ev(1));
      end
      tests++;
      if (!$onehot0(g_fp) || !$onehot0(g_rr)) begin
        fails++; $display("FAIL rand_onehot_%0d: got %h/%h expected zero or one-hot", i, g_fp, g_rr);
      end
    end
    rst = 0; lock = 0; req = 0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_fixed;
    test_round_robin;
    test_lock;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
